// File: rtl/seq_capture_fsm.sv
// Serial bit-stream capture FSM: assembles WIDTH bits MSB first, compares against PATTERN,
// and reports the result on one-hot state LEDs and an active-low seven-segment digit.
module seq_capture_fsm #(
    parameter int               WIDTH   = 10,
    parameter logic [WIDTH-1:0] PATTERN = 10'b1010101010,
    parameter int               TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             switch_pause,
    input  logic             clear,
    output logic [WIDTH-1:0] captured,
    output logic             match,
    output logic             timeout_err,
    output logic [6:0]       seg_display,
    output logic [3:0]       led_state
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [3:0]       bit_count;
    logic [TW-1:0]    tmo_cnt;
    logic             match_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_count   <= '0;
            tmo_cnt     <= '0;
            match_r     <= 1'b0;
            timeout_err <= 1'b0;
        end else if (clear) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_count   <= '0;
            tmo_cnt     <= '0;
            match_r     <= 1'b0;
            timeout_err <= 1'b0;
        end else if (switch_pause) begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (bit_valid) begin
                        shreg     <= {shreg[WIDTH-2:0], bit_in};
                        bit_count <= 4'd1;
                        tmo_cnt   <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_valid) begin
                        shreg     <= {shreg[WIDTH-2:0], bit_in};
                        bit_count <= bit_count + 4'd1;
                        tmo_cnt   <= '0;
                        if (bit_count == 4'(WIDTH - 1))
                            state <= CHECK;
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        // Abandon the partial word after TIMEOUT running cycles without a bit
                        state       <= IDLE;
                        shreg       <= '0;
                        bit_count   <= '0;
                        tmo_cnt     <= '0;
                        timeout_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    match_r <= (shreg == PATTERN);
                    state   <= DONE;
                end
                default: ;
            endcase
        end
    end

    assign captured = shreg;
    assign match    = (state == DONE) && match_r;

    always_comb begin
        led_state = 4'b0001;
        case (state)
            IDLE:    led_state = 4'b0001;
            SHIFT:   led_state = 4'b0010;
            CHECK:   led_state = 4'b0100;
            DONE:    led_state = 4'b1000;
            default: led_state = 4'b0001;
        endcase
    end

    always_comb begin
        seg_display = 7'b1000000;
        if (state == DONE) begin
            seg_display = match_r ? 7'b0001100 : 7'b0001110;
        end else begin
            case (bit_count)
                4'h0: seg_display = 7'b1000000;
                4'h1: seg_display = 7'b1111001;
                4'h2: seg_display = 7'b0100100;
                4'h3: seg_display = 7'b0110000;
                4'h4: seg_display = 7'b0011001;
                4'h5: seg_display = 7'b0010010;
                4'h6: seg_display = 7'b0000010;
                4'h7: seg_display = 7'b1111000;
                4'h8: seg_display = 7'b0000000;
                4'h9: seg_display = 7'b0010000;
                4'hA: seg_display = 7'b0001000;
                4'hB: seg_display = 7'b0000011;
                4'hC: seg_display = 7'b1000110;
                4'hD: seg_display = 7'b0100001;
                4'hE: seg_display = 7'b0000110;
                4'hF: seg_display = 7'b0001110;
                default: seg_display = 7'b1000000;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_capture_fsm.sv
// Bench for seq_capture_fsm: directed scenarios plus randomized traffic, all compared every
// cycle against a queue-based model of the capture rules.
module tb_seq_capture_fsm;
    localparam int           W   = 10;
    localparam logic [W-1:0] PAT = 10'b1010101010;
    localparam int           TMO = 64;
    localparam logic [6:0]   SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    localparam logic [6:0]   SEG_P = 7'h0C;
    localparam logic [6:0]   SEG_F = 7'h0E;

    logic clk = 1'b0, rst = 1'b1, bit_in = 1'b0, bit_valid = 1'b0;
    logic switch_pause = 1'b1, clear = 1'b0;
    logic [W-1:0] captured;
    logic match, timeout_err;
    logic [6:0] seg_display;
    logic [3:0] led_state;

    int checks = 0, failures = 0;

    // Model: accepted bits in arrival order, plus result flags
    bit mq[$];
    int mtmo = 0;
    bit mchk = 0, mdone = 0, mmatch = 0, mterr = 0;

    seq_capture_fsm #(.WIDTH(W), .PATTERN(PAT), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .switch_pause(switch_pause), .clear(clear), .captured(captured), .match(match),
        .timeout_err(timeout_err), .seg_display(seg_display), .led_state(led_state)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mword();
        logic [W-1:0] w = '0;
        foreach (mq[i]) w = {w[W-2:0], mq[i]};
        return w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        mq.delete();
        mtmo = 0; mchk = 0; mdone = 0; mmatch = 0; mterr = 0;
    endtask

    task automatic m_step();
        if (rst || clear) begin
            m_reset();
        end else if (switch_pause) begin
            mterr = 0;
            if (mdone) begin
            end else if (mchk) begin
                mmatch = (mword() == PAT);
                mchk = 0;
                mdone = 1;
            end else if (bit_valid) begin
                mq.push_back(bit_in);
                mtmo = 0;
                if (mq.size() == W) mchk = 1;
            end else if (mq.size() > 0) begin
                if (mtmo == TMO - 1) begin
                    mq.delete();
                    mtmo = 0;
                    mterr = 1;
                end else begin
                    mtmo++;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [3:0] e_led;
        logic [6:0] e_seg;
        e_led = mdone ? 4'b1000 : mchk ? 4'b0100 : (mq.size() > 0) ? 4'b0010 : 4'b0001;
        e_seg = mdone ? (mmatch ? SEG_P : SEG_F) : SEG[mq.size()];
        chk("cyc_captured", 32'(captured), 32'(mword()));
        chk("cyc_match", 32'(match), 32'(mdone && mmatch));
        chk("cyc_timeout_err", 32'(timeout_err), 32'(mterr));
        chk("cyc_led", 32'(led_state), 32'(e_led));
        chk("cyc_seg", 32'(seg_display), 32'(e_seg));
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic send(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic feed(input logic [W-1:0] word, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            send(word[n-1-i]);
            if (i != n - 1) repeat (gap - 1) tick();
        end
    endtask

    initial begin
        // Reset with bit_valid toggling
        for (int i = 0; i < 2; i++) begin
            bit_valid = i[0];
            tick();
        end
        bit_valid = 1'b0;
        chk("rst_led", 32'(led_state), 32'h1);
        chk("rst_seg", 32'(seg_display), 32'h40);
        chk("rst_captured", 32'(captured), 32'h0);
        chk("rst_match", 32'(match), 32'h0);
        rst = 1'b0;
        tick();

        // Matching word, one strobe every 4 cycles
        feed(PAT, W, 4);
        chk("match_check_led", 32'(led_state), 32'h4);
        tick();
        chk("match_done_led", 32'(led_state), 32'h8);
        chk("match_captured", 32'(captured), 32'h2AA);
        chk("match_match", 32'(match), 32'h1);
        chk("match_seg", 32'(seg_display), 32'h0C);
        repeat (3) tick();
        chk("done_hold_match", 32'(match), 32'h1);
        clear = 1'b1; tick(); clear = 1'b0;

        // Mismatching word, then clear
        feed(10'b1111100000, W, 2);
        tick();
        chk("mis_match", 32'(match), 32'h0);
        chk("mis_seg", 32'(seg_display), 32'h0E);
        chk("mis_captured", 32'(captured), 32'h3E0);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clr_led", 32'(led_state), 32'h1);
        chk("clr_seg", 32'(seg_display), 32'h40);

        // Pause drops strobes
        feed(10'b10101, 5, 3);
        switch_pause = 1'b0;
        feed(10'b111, 3, 2);
        chk("pause_led", 32'(led_state), 32'h2);
        chk("pause_seg", 32'(seg_display), 32'h12);
        chk("pause_captured", 32'(captured), 32'h15);
        switch_pause = 1'b1;
        feed(10'b01010, 5, 3);
        tick();
        chk("pause_done_match", 32'(match), 32'h1);
        chk("pause_done_captured", 32'(captured), 32'h2AA);
        clear = 1'b1; tick(); clear = 1'b0;

        // Timeout after 64 idle running cycles
        feed(10'b110, 3, 2);
        repeat (TMO - 1) tick();
        chk("tmo_early_err", 32'(timeout_err), 32'h0);
        chk("tmo_early_led", 32'(led_state), 32'h2);
        tick();
        chk("tmo_err", 32'(timeout_err), 32'h1);
        chk("tmo_led", 32'(led_state), 32'h1);
        chk("tmo_captured", 32'(captured), 32'h0);
        tick();
        chk("tmo_pulse_end", 32'(timeout_err), 32'h0);

        // Pause inside the gap does not count
        feed(10'b011, 3, 2);
        repeat (20) tick();
        switch_pause = 1'b0;
        repeat (40) tick();
        switch_pause = 1'b1;
        repeat (TMO - 21) tick();
        chk("tmo_pause_led", 32'(led_state), 32'h2);
        chk("tmo_pause_err0", 32'(timeout_err), 32'h0);
        tick();
        chk("tmo_pause_err1", 32'(timeout_err), 32'h1);
        tick();

        // Async reset between edges mid-word
        feed(10'b1011011, 7, 1);
        #2;
        rst = 1'b1;
        m_reset();
        #1;
        chk("arst_led", 32'(led_state), 32'h1);
        chk("arst_seg", 32'(seg_display), 32'h40);
        chk("arst_captured", 32'(captured), 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Clear and bit_valid together in DONE
        feed(PAT, W, 1);
        tick();
        chk("cb_done_led", 32'(led_state), 32'h8);
        clear = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        tick();
        clear = 1'b0; bit_valid = 1'b0;
        chk("cb_led", 32'(led_state), 32'h1);
        chk("cb_captured", 32'(captured), 32'h0);
        chk("cb_seg", 32'(seg_display), 32'h40);
        tick();

        // Randomized traffic with dense and sparse strobe phases
        begin
            bit dense = 1'b1;
            for (int k = 0; k < 4000; k++) begin
                if (k % 200 == 0) dense = 1'($urandom_range(1, 0));
                bit_valid    = dense ? ($urandom_range(2, 0) == 0) : ($urandom_range(79, 0) == 0);
                bit_in       = 1'($urandom);
                switch_pause = ($urandom_range(9, 0) != 0);
                clear        = ($urandom_range(149, 0) == 0);
                if (rst) begin
                    rst = 1'b0;
                end else if ($urandom_range(599, 0) == 0) begin
                    rst = 1'b1;
                    m_reset();
                end
                tick();
            end
        end
        bit_valid = 1'b0; clear = 1'b0; switch_pause = 1'b1; rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
